key_pulse: RTL and testbench
============================

KEY_PULSE -- requirements
Module: key_pulse

Interface
REQ-001 Parameter DIV, default 1000: clocks per sample tick; legal range 2 or more.
REQ-002 Parameter STABLE, default 4: consecutive equal samples needed to confirm a level change; legal range 2 to 15.
REQ-003 clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 key_in  input  1  raw push-button level, asynchronous to clk, 1 = pressed.
REQ-006 x  output  1  one-clock, active-high pulse per confirmed press; drives a BCD counter's increment input directly.
REQ-007 key_level  output  1  debounced button level.
REQ-008 tick  output  1  sample strobe, high for one clock every DIV clocks; debug and verification use only.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; key_s is the second flop, and only key_s feeds the FSM.
REQ-010 Divider SHALL count 0 to DIV-1 and wrap to 0; tick SHALL be 1 exactly when the count equals DIV-1.
REQ-011 Sample counter scnt SHALL be 4 bits wide and SHALL change only on clocks where tick=1.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT; no transition SHALL occur when tick=0.
REQ-013 IDLE, on tick: key_s=1 -> PRESS_WAIT with scnt=1; key_s=0 -> stay in IDLE.
REQ-014 PRESS_WAIT, on tick:
- key_s=0 -> IDLE with scnt=0.
- key_s=1 and scnt+1=STABLE -> PRESSED with scnt=0.
- key_s=1 otherwise -> scnt increments.
REQ-015 PRESSED, on tick: key_s=0 -> RELEASE_WAIT with scnt=1; key_s=1 -> stay in PRESSED.
REQ-016 RELEASE_WAIT, on tick:
- key_s=1 -> PRESSED with scnt=0, and no new pulse.
- key_s=0 and scnt+1=STABLE -> IDLE with scnt=0.
- key_s=0 otherwise -> scnt increments.
REQ-017 x SHALL be registered and SHALL be 1 only in the clock cycle immediately after the edge that moves PRESS_WAIT to PRESSED.
REQ-018 x SHALL never be high for two consecutive cycles.
REQ-019 At most one x pulse SHALL occur per IDLE-to-PRESSED traversal.
REQ-020 key_level SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT; it is registered from the state.
REQ-021 Bounce shorter than STABLE ticks in either direction SHALL produce no x pulse and no change of key_level.
REQ-022 The unreachable state encoding SHALL return to IDLE on the next clock.
REQ-023 Worst-case press latency, from key_s rising to x=1, SHALL be at most STABLE*DIV+1 clocks.

Reset
REQ-024 While reset=0 at a rising edge, the block SHALL load all of the following, regardless of key_in:
- state = IDLE;
- divider = 0 and scnt = 0;
- both synchronizer flops = 0;
- x = 0, key_level = 0, tick = 0.
REQ-025 Reset asserted mid-operation (PRESS_WAIT, PRESSED or RELEASE_WAIT) SHALL discard all progress; no x pulse SHALL be emitted for that press.
REQ-026 After reset is released with key_in held at 1, the block SHALL emit exactly one x pulse after STABLE full ticks, as for a fresh press.

Verification (bench uses DIV=4, STABLE=3)
REQ-027 Reset: hold reset=0 for 3 clocks with key_in=1 -> x=0, key_level=0, tick=0 throughout; the first tick occurs on the 4th clock after release.
REQ-028 Clean press: key_in=1 held for 40 clocks, then 0 for 40 clocks -> exactly one x pulse, 1 clock wide, one clock after the 3rd tick with key_s=1; key_level returns to 0 after 3 ticks of key_s=0.
REQ-029 Bouncy press: key_in toggling every 3 clocks for 24 clocks, then steady 1 for 30 clocks -> exactly one x pulse total; zero pulses during the toggling.
REQ-030 Glitch: key_in=1 for 6 clocks (at most 2 ticks) -> x stays 0 and key_level stays 0.
REQ-031 Release bounce: confirmed press, then key_in=0 for 5 clocks and back to 1 -> key_level stays 1 and no second pulse; a full release followed by a re-press gives a second pulse.
REQ-032 Reset mid-PRESS_WAIT (after 2 ticks with key_s=1), key_in still held -> no pulse during reset; one pulse 3 full ticks after release, plus the synchronizer delay; the downstream counter advances by exactly 1.

Source files
------------

// File: rtl/key_pulse.sv
// key_pulse: push-button debouncer for a BCD counter's increment input.
// The raw key is synchronised, sampled once per tick, and confirmed by a
// four-state FSM. Each confirmed press gives exactly one clock-wide pulse on x.
module key_pulse #(
    parameter int DIV    = 1000,
    parameter int STABLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic x,
    output logic key_level,
    output logic tick
);

    localparam int              DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]      STABLE_C = 4'(STABLE);

    // All four encodings are used. The default branch still forces IDLE so that a
    // corrupted state register recovers on the next clock.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic          r_tick;
    logic [3:0]    r_scnt;
    logic [3:0]    w_scnt_next;
    logic [3:0]    w_scnt_inc;
    logic          w_stable_hit;
    state_t        r_state;
    state_t        w_state_next;
    logic          w_pulse;
    logic          r_x;
    logic          r_level;

    assign w_div_next   = (r_div == DIV_LAST) ? {DW{1'b0}} : (r_div + DW'(1));
    assign w_scnt_inc   = r_scnt + 4'd1;
    assign w_stable_hit = (w_scnt_inc == STABLE_C);

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sample divider. The registered tick is high while the count sits at DIV-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div  <= {DW{1'b0}};
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == DIV_LAST);
        end
    end

    // Next-state, sample-count and press-pulse logic. It only advances on tick.
    always_comb begin
        w_state_next = r_state;
        w_scnt_next  = r_scnt;
        w_pulse      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_tick && r_sync2) begin
                    w_state_next = PRESS_WAIT;
                    w_scnt_next  = 4'd1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (r_tick && !r_sync2) begin
                    w_state_next = IDLE;
                    w_scnt_next  = 4'd0;
                end else if (r_tick && w_stable_hit) begin
                    w_state_next = PRESSED;
                    w_scnt_next  = 4'd0;
                    w_pulse      = 1'b1;
                end else if (r_tick) begin
                    w_scnt_next  = w_scnt_inc;
                end else begin
                    w_state_next = PRESS_WAIT;
                end
            end
            PRESSED: begin
                if (r_tick && !r_sync2) begin
                    w_state_next = RELEASE_WAIT;
                    w_scnt_next  = 4'd1;
                end else begin
                    w_state_next = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                // A key that returns high before release is confirmed is the same press.
                if (r_tick && r_sync2) begin
                    w_state_next = PRESSED;
                    w_scnt_next  = 4'd0;
                end else if (r_tick && w_stable_hit) begin
                    w_state_next = IDLE;
                    w_scnt_next  = 4'd0;
                end else if (r_tick) begin
                    w_scnt_next  = w_scnt_inc;
                end else begin
                    w_state_next = RELEASE_WAIT;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_scnt_next  = 4'd0;
            end
        endcase
    end

    // State, sample count and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_scnt  <= 4'd0;
            r_x     <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_scnt  <= w_scnt_next;
            r_x     <= w_pulse;
            r_level <= (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);
        end
    end

    assign x         = r_x;
    assign key_level = r_level;
    assign tick      = r_tick;

endmodule

// File: tb/tb_key_pulse.sv
// Directed bench for key_pulse with DIV=4 and STABLE=3.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// A negedge monitor counts x pulses and key_level samples, and the stimulus
// compares count deltas against hand-computed values.
module tb_key_pulse;

    logic clk;
    logic reset;
    logic key_in;
    logic x;
    logic key_level;
    logic tick;

    int checks;
    int failures;
    int pulse_cnt   = 0;
    int double_cnt  = 0;
    int lvl_hi_cnt  = 0;
    int lvl_lo_cnt  = 0;
    logic prev_x    = 1'b0;
    logic [3:0] bcd = 4'd0;

    key_pulse #(.DIV(4), .STABLE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .x         (x),
        .key_level (key_level),
        .tick      (tick)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Downstream BCD digit that is incremented by x.
    always @(posedge clk) begin
        if (x === 1'b1) bcd <= (bcd == 4'd9) ? 4'd0 : bcd + 4'd1;
    end

    // Pulse and level monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (x === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            if (prev_x) double_cnt <= double_cnt + 1;
        end
        prev_x <= (x === 1'b1);
        if (key_level === 1'b1) lvl_hi_cnt <= lvl_hi_cnt + 1;
        else                    lvl_lo_cnt <= lvl_lo_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Hold reset for three clocks, then release it with key_in still at 1.
    // After release, tick is expected in cycles 4, 8, ... and the only x pulse in cycle 13.
    task automatic reset_window(input string tag);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_rst_x"},    x,         32'd0);
            check_eq({tag, "_rst_lvl"},  key_level, 32'd0);
            check_eq({tag, "_rst_tick"}, tick,      32'd0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            check_eq({tag, "_tick"}, tick, (k % 4 == 0) ? 32'd1 : 32'd0);
            check_eq({tag, "_x"},    x,    (k == 13)    ? 32'd1 : 32'd0);
            if (k == 12 || k == 13)
                check_eq({tag, "_lvl"}, key_level, (k == 13) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = 0;
        while (seen < n && budget < 100) begin
            if (tick === 1'b1) seen++;
            if (seen < n) begin
                @(negedge clk);
                budget++;
            end
        end
        check_eq("tick_wait", seen, n);
    endtask

    initial begin
        int p0;
        int h0;
        int l0;
        logic [3:0] b0;
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset    = 1'b0;
        key_in   = 1'b1;

        // Reset state, first tick and power-up press with the key held.
        reset_window("por");

        // Release fully, then do a clean press and release.
        hold(1'b0, 40);
        #1 check_eq("rel0_lvl", key_level, 32'd0);
        p0 = pulse_cnt;
        hold(1'b1, 40);
        #1 check_eq("clean_pulses", pulse_cnt - p0, 32'd1);
        check_eq("clean_lvl_hi", key_level, 32'd1);
        p0 = pulse_cnt;
        hold(1'b0, 40);
        #1 check_eq("clean_rel_pulses", pulse_cnt - p0, 32'd0);
        check_eq("clean_lvl_lo", key_level, 32'd0);

        // A glitch spanning at most two ticks.
        p0 = pulse_cnt; h0 = lvl_hi_cnt;
        hold(1'b1, 6);
        hold(1'b0, 30);
        #1 check_eq("glitch_pulses", pulse_cnt - p0, 32'd0);
        check_eq("glitch_lvl_hi", lvl_hi_cnt - h0, 32'd0);

        // Bouncy press: toggle every 3 clocks, then hold the key steady.
        p0 = pulse_cnt; h0 = lvl_hi_cnt;
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        #1 check_eq("bounce_pulses", pulse_cnt - p0, 32'd0);
        check_eq("bounce_lvl_hi", lvl_hi_cnt - h0, 32'd0);
        p0 = pulse_cnt;
        hold(1'b1, 30);
        #1 check_eq("bounce_steady_pulses", pulse_cnt - p0, 32'd1);
        check_eq("bounce_steady_lvl", key_level, 32'd1);

        // Release bounce: a 5-clock low does not end the press.
        p0 = pulse_cnt; l0 = lvl_lo_cnt;
        hold(1'b0, 5);
        hold(1'b1, 30);
        #1 check_eq("relb_pulses", pulse_cnt - p0, 32'd0);
        check_eq("relb_lvl_lo", lvl_lo_cnt - l0, 32'd0);
        hold(1'b0, 40);
        #1 check_eq("relb_full_lvl", key_level, 32'd0);
        p0 = pulse_cnt;
        hold(1'b1, 30);
        #1 check_eq("repress_pulses", pulse_cnt - p0, 32'd1);
        hold(1'b0, 40);

        // Reset after two ticks in PRESS_WAIT, with the key still held.
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        wait_ticks(2);
        @(posedge clk);
        #1;
        p0 = pulse_cnt;
        b0 = bcd;
        reset_window("mid");
        #1 check_eq("mid_pulses", pulse_cnt - p0, 32'd1);
        check_eq("mid_bcd", bcd, (b0 == 4'd9) ? 32'd0 : 32'(b0) + 32'd1);

        check_eq("x_two_cycles", double_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
